mac_unit_pragmatic_seq: RTL and testbench

MAC_UNIT_PRAGMATIC_SEQ -- requirements
Module: mac_unit_pragmatic_seq

---
 rtl/mac_unit_pragmatic_seq.sv | 150 +++++++++++++++
 tb/tb_mac_unit_pragmatic_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_unit_pragmatic_seq.sv
// Sequential bit-pragmatic MAC: latches an activation vector, then accumulates
// shift/negate-encoded weight terms beat by beat into a wrapping accumulator.

module mac_unit_pragmatic_seq_lane #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT1_BITS = 2,
  parameter int LANE_W      = DATA_WIDTH + 1 + (2**SHIFT1_BITS - 1)
) (
  input  logic [DATA_WIDTH-1:0]  act_i,
  input  logic [SHIFT1_BITS-1:0] sel_i,
  input  logic                   en_i,
  input  logic                   neg_i,
  output logic [LANE_W-1:0]      lane_o
);
  logic [DATA_WIDTH:0] act_x;
  logic [DATA_WIDTH:0] val;
  logic [LANE_W-1:0]   ext;

  // One extra bit so negating the most-negative activation cannot overflow.
  assign act_x  = {act_i[DATA_WIDTH-1], act_i};
  assign val    = neg_i ? -act_x : act_x;
  assign ext    = {{(LANE_W-DATA_WIDTH-1){val[DATA_WIDTH]}}, val};
  assign lane_o = en_i ? (ext << sel_i) : '0;
endmodule

module mac_unit_pragmatic_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int VEC_LENGTH  = 16,
  parameter int SHIFT1_BITS = 2,
  parameter int SHIFT2_BITS = 3,
  parameter int ACC_WIDTH   = DATA_WIDTH + 16,
  parameter int MAX_TERMS   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              in_ready,
  input  logic                              load_accum,
  input  logic [ACC_WIDTH-1:0]              accum_prev,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]  act_in,
  input  logic                              term_valid,
  output logic                              term_ready,
  input  logic                              term_last,
  input  logic [VEC_LENGTH*SHIFT1_BITS-1:0] shift1_sel,
  input  logic [VEC_LENGTH-1:0]             shift1_en,
  input  logic [VEC_LENGTH-1:0]             is_neg,
  input  logic [SHIFT2_BITS-1:0]            shift2_sel,
  input  logic                              shift2_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH-1:0]              result,
  output logic                              term_overflow
);
  localparam int LANE_W = DATA_WIDTH + 1 + (2**SHIFT1_BITS - 1);
  localparam int SUM_W  = LANE_W + $clog2(VEC_LENGTH);
  localparam int SHW    = SUM_W + (2**SHIFT2_BITS - 1);
  localparam int EXT_W  = (SHW > ACC_WIDTH) ? SHW : ACC_WIDTH;
  localparam int CNT_W  = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                          state_q, state_d;
  logic [ACC_WIDTH-1:0]            acc_q, acc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q, act_d;
  logic                            ovf_q, ovf_d;

  logic [VEC_LENGTH-1:0][LANE_W-1:0] lanes;
  logic [SUM_W-1:0]                  lane_sum;
  logic [EXT_W-1:0]                  sum_ext;
  logic [EXT_W-1:0]                  sum_sh;
  logic [ACC_WIDTH-1:0]              term;

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    mac_unit_pragmatic_seq_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT1_BITS(SHIFT1_BITS),
      .LANE_W     (LANE_W)
    ) u_lane (
      .act_i (act_q[j*DATA_WIDTH +: DATA_WIDTH]),
      .sel_i (shift1_sel[j*SHIFT1_BITS +: SHIFT1_BITS]),
      .en_i  (shift1_en[j]),
      .neg_i (is_neg[j]),
      .lane_o(lanes[j])
    );
  end

  // Full-precision lane sum; the shared shift is applied before truncating to ACC_WIDTH.
  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < VEC_LENGTH; j++)
      lane_sum = lane_sum + {{(SUM_W-LANE_W){lanes[j][LANE_W-1]}}, lanes[j]};
  end

  assign sum_ext = {{(EXT_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
  assign sum_sh  = sum_ext << shift2_sel;
  assign term    = shift2_en ? sum_sh[ACC_WIDTH-1:0] : '0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (start) begin
        act_d   = act_in;
        acc_d   = load_accum ? accum_prev : '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: if (term_valid) begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + 1'b1;
        if (term_last) begin
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(MAX_TERMS - 1)) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign term_ready    = (state_q == ACCUM);
  assign out_valid     = (state_q == DONE);
  assign result        = acc_q;
  assign term_overflow = ovf_q;
endmodule

// File: tb/tb_mac_unit_pragmatic_seq.sv
// Directed + random bench for mac_unit_pragmatic_seq with a result scoreboard.
module tb_mac_unit_pragmatic_seq;
  localparam int DW = 8, VL = 16, S1 = 2, S2 = 3, ACC = 24, MT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, in_ready, load_accum;
  logic [ACC-1:0]    accum_prev;
  logic [VL*DW-1:0]  act_in;
  logic              term_valid, term_ready, term_last;
  logic [VL*S1-1:0]  shift1_sel;
  logic [VL-1:0]     shift1_en, is_neg;
  logic [S2-1:0]     shift2_sel;
  logic              shift2_en, out_valid, out_ready, term_overflow;
  logic [ACC-1:0]    result;

  mac_unit_pragmatic_seq #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT1_BITS(S1),
    .SHIFT2_BITS(S2), .ACC_WIDTH(ACC), .MAX_TERMS(MT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
    .load_accum(load_accum), .accum_prev(accum_prev), .act_in(act_in),
    .term_valid(term_valid), .term_ready(term_ready), .term_last(term_last),
    .shift1_sel(shift1_sel), .shift1_en(shift1_en), .is_neg(is_neg),
    .shift2_sel(shift2_sel), .shift2_en(shift2_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .term_overflow(term_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [63:0] res; logic ovf; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  int act[VL], act_m[VL], s1[VL];
  bit en[VL], neg[VL];
  logic signed [63:0] exp_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] wrap(longint v);
    logic signed [ACC-1:0] t;
    t = v[ACC-1:0];
    return t;
  endfunction

  function automatic longint model_term(int s2, bit s2en);
    longint sum, l;
    sum = 0;
    for (int j = 0; j < VL; j++) begin
      l = neg[j] ? -longint'(act_m[j]) : longint'(act_m[j]);
      l = l * (longint'(1) << s1[j]);
      if (en[j]) sum += l;
    end
    return s2en ? sum * (longint'(1) << s2) : 0;
  endfunction

  task automatic set_acts();
    for (int j = 0; j < VL; j++) act_in[j*DW +: DW] = act[j][DW-1:0];
  endtask

  task automatic set_ctrl();
    for (int j = 0; j < VL; j++) begin
      shift1_sel[j*S1 +: S1] = s1[j][S1-1:0];
      shift1_en[j] = en[j];
      is_neg[j]    = neg[j];
    end
  endtask

  task automatic lanes_uniform(int a, int sh, bit e, bit n);
    for (int j = 0; j < VL; j++) begin
      act[j] = a; s1[j] = sh; en[j] = e; neg[j] = n;
    end
  endtask

  task automatic start_op(string tag, bit la, longint prev);
    set_acts();
    chk({tag, "_in_ready"}, in_ready, 1);
    start = 1'b1; load_accum = la; accum_prev = prev[ACC-1:0];
    tick();
    start = 1'b0;
    exp_acc = la ? wrap(prev) : 0;
    act_m = act;
    act_in = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_seed"}, $signed(result), exp_acc);
    chk({tag, "_term_ready"}, term_ready, 1);
  endtask

  task automatic beat(int s2, bit s2en, bit last);
    set_ctrl();
    shift2_sel = s2[S2-1:0]; shift2_en = s2en; term_last = last; term_valid = 1'b1;
    tick();
    term_valid = 1'b0; term_last = 1'b0;
    exp_acc = wrap(exp_acc + model_term(s2, s2en));
  endtask

  task automatic push_exp(bit ovf);
    exp_t e;
    e.res = exp_acc; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic wait_result(string tag, int max_wait);
    exp_t e;
    int n;
    n = 0;
    while (!out_valid && n < max_wait) begin tick(); n++; end
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, $signed(result), e.res);
      chk({tag, "_overflow"}, term_overflow, e.ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, in_ready, 1);
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 0; load_accum = 0; accum_prev = '0; act_in = '0;
    term_valid = 0; term_last = 0; shift1_sel = '0; shift1_en = '0; is_neg = '0;
    shift2_sel = '0; shift2_en = 0; out_ready = 0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_term_ready", term_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", term_overflow, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Basic: 3*2 per lane *16 lanes <<2 = 384, out_valid right after the last beat.
    lanes_uniform(3, 1, 1, 0);
    start_op("basic", 0, 0);
    beat(2, 1, 1); push_exp(0);
    wait_result("basic", 0);

    // Most-negative activation negated: 128<<3 *16 <<7 = 2097152.
    lanes_uniform(-128, 3, 1, 1);
    start_op("negmax", 0, 0);
    beat(7, 1, 1); push_exp(0);
    wait_result("negmax", 0);

    // Seeded accumulation, single lane, idle gaps hold acc: -1000+5+5.
    lanes_uniform(100, 0, 0, 0);
    act[0] = 5; en[0] = 1;
    start_op("seed", 1, -1000);
    beat(0, 1, 0);
    repeat (2) begin
      tick();
      chk("seed_hold", $signed(result), exp_acc);
      chk("seed_hold_ready", term_ready, 1);
    end
    beat(0, 1, 1); push_exp(0);
    chk("seed_exp_value", exp_acc, -990);
    wait_result("seed", 3);

    // Overflow: 9 offered, only 8 accepted.
    lanes_uniform(1, 0, 1, 0);
    start_op("ovf", 0, 0);
    for (int i = 0; i < MT; i++) beat(0, 1, 0);
    push_exp(1);
    chk("ovf_9th_ready", term_ready, 0);
    term_valid = 1'b1; tick(); term_valid = 1'b0;
    wait_result("ovf", 0);

    // term_last on the MAX_TERMS-th beat wins over overflow.
    start_op("lastwin", 0, 0);
    for (int i = 0; i < MT - 1; i++) beat(1, 1, 0);
    beat(1, 1, 1); push_exp(0);
    wait_result("lastwin", 0);

    // Stall in DONE with stray start/term_valid.
    lanes_uniform(-7, 2, 1, 0);
    start_op("stall", 0, 0);
    beat(3, 1, 1); push_exp(0);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; term_valid = 1'b1; term_last = 1'b1; out_ready = 1'b0;
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_result", $signed(result), sb[0].res);
      chk("stall_in_ready", in_ready, 0);
    end
    start = 0; term_valid = 0; term_last = 0;
    wait_result("stall", 0);

    // Wrap at ACC_WIDTH: (2^23-1)+384 wraps negative.
    lanes_uniform(3, 1, 1, 0);
    start_op("wrap", 1, 64'sd8388607);
    beat(2, 1, 1); push_exp(0);
    chk("wrap_exp_value", exp_acc, -8388225);
    wait_result("wrap", 0);

    // shift2_en=0 zeroes the whole term.
    start_op("s2off", 1, 77);
    beat(5, 0, 1); push_exp(0);
    wait_result("s2off", 0);

    // Async reset mid-ACCUM after 3 terms.
    lanes_uniform(9, 1, 1, 0);
    start_op("arst", 1, 5000);
    repeat (3) beat(1, 1, 0);
    reset = 1'b1;
    #1;
    chk("arst_result", result, 0);
    chk("arst_term_ready", term_ready, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_overflow", term_overflow, 0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("arst_no_valid", out_valid, 0);
      chk("arst_idle", in_ready, 1);
    end
    lanes_uniform(2, 0, 1, 0);
    start_op("post_rst", 0, 0);
    beat(0, 1, 1); push_exp(0);
    wait_result("post_rst", 0);

    // Random operations.
    for (int k = 0; k < 6; k++) begin
      int nb;
      for (int j = 0; j < VL; j++) act[j] = int'($urandom_range(255)) - 128;
      start_op("rnd", $urandom_range(1), longint'(int'($urandom)) % 4000000);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < VL; j++) begin
          s1[j] = $urandom_range(3); en[j] = $urandom_range(1); neg[j] = $urandom_range(1);
        end
        beat($urandom_range(7), $urandom_range(3) != 0, b == nb - 1);
      end
      push_exp(0);
      wait_result("rnd", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
